// File: rtl/siso_ctrl_pkg.sv
// Shared types and helpers for the SISO loopback sequencer.
package siso_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // Counter width able to reach WIDTH+DEPTH-1 without wrapping.
    function automatic int unsigned cnt_width(input int unsigned width, input int unsigned depth);
        return (width + depth > 1) ? $clog2(width + depth) : 1;
    endfunction

endpackage

// File: rtl/sipo_capture.sv
// Indexed capture register: writes one returning serial bit per enabled cycle.
// word_next_o exposes the value including the bit being written this cycle,
// so the parent can latch a complete word on the same edge as the final bit.
module sipo_capture #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en_i,
    input  logic [IW-1:0]    idx_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] word_o,
    output logic [WIDTH-1:0] word_next_o
);

    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_d;

    // Merge the incoming bit into its slot when enabled.
    always_comb begin
        word_d = word_q;
        if (load_en_i) begin
            word_d[idx_i] = bit_i;
        end
    end

    // Capture register.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word_o      = word_q;
    assign word_next_o = word_d;

endmodule

// File: rtl/siso_loop_ctrl.sv
// Sequencer for an external DEPTH-stage SISO line: serialises an accepted word
// LSB-first onto si, captures it back from so DEPTH clocks later, and presents
// the returned word with a loopback mismatch flag.
module siso_loop_ctrl
    import siso_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             si,
    input  logic             so,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             mismatch,
    output logic             busy
);

    localparam int unsigned CW = cnt_width(WIDTH, DEPTH);
    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH + DEPTH - 1);
    localparam logic [CW-1:0] CAP_LO   = CW'(DEPTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic             si_q, si_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             mismatch_q, mismatch_d;

    logic [WIDTH-1:0] tx_shifted;
    logic             cap_en;
    logic [IW-1:0]    cap_idx;
    logic [WIDTH-1:0] rx_word;
    logic [WIDTH-1:0] rx_next;

    assign tx_shifted = tx_sh_q >> 1;
    assign cap_en     = (state_q == S_RUN) && (cnt_q >= CAP_LO);
    assign cap_idx    = IW'(cnt_q - CAP_LO);

    sipo_capture #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_capture (
        .clk         (clk),
        .rst         (rst),
        .load_en_i   (cap_en),
        .idx_i       (cap_idx),
        .bit_i       (so),
        .word_o      (rx_word),
        .word_next_o (rx_next)
    );

    // Next-state, serialiser and result logic.
    // si is registered, so it is loaded one cycle ahead: word[0] on accept,
    // then the next bit of the shifting copy on every RUN edge.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tx_sh_d     = tx_sh_q;
        tx_d        = tx_q;
        si_d        = 1'b0;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        mismatch_d  = mismatch_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    tx_sh_d = in_data;
                    tx_d    = in_data;
                    si_d    = in_data[0];
                end
            end
            S_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    state_d     = S_HOLD;
                    out_data_d  = rx_next;
                    out_valid_d = 1'b1;
                    mismatch_d  = (rx_next != tx_q);
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    tx_sh_d = tx_shifted;
                    si_d    = tx_shifted[0];
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    mismatch_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            tx_sh_q     <= '0;
            tx_q        <= '0;
            si_q        <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            mismatch_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tx_sh_q     <= tx_sh_d;
            tx_q        <= tx_d;
            si_q        <= si_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            mismatch_q  <= mismatch_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign si        = si_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign mismatch  = mismatch_q;

    // The last registered capture value is superseded by out_data; kept for visibility.
    logic rx_unused;
    assign rx_unused = ^rx_word;

endmodule

// File: tb/tb_siso_loop_ctrl.sv
// Bench for siso_loop_ctrl with a 4-stage SISO line model between si and so.
module tb_siso_loop_ctrl;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         si;
    logic         so;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         mismatch;
    logic         busy;

    logic         force_so = 1'b0;
    logic [D-1:0] line_q;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    typedef struct {
        logic [W-1:0] data;
        logic         mis;
        int           acc;
    } exp_t;

    exp_t exp_q[$];
    int   rise_q[$];
    exp_t mon_e;
    logic ov_prev = 1'b0;

    siso_loop_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .si        (si),
        .so        (so),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mismatch  (mismatch),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // External SISO line, reset together with the controller.
    always @(posedge clk) begin
        if (rst) line_q <= '0;
        else     line_q <= {line_q[D-2:0], si};
    end
    assign so = force_so ? 1'b0 : line_q[D-1];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    endtask

    // Monitor: latency on each out_valid rise, scoreboard compare on each handshake.
    always begin
        @(negedge clk);
        #1;
        if (rst) begin
            ov_prev = 1'b0;
        end else begin
            if (out_valid && !ov_prev) begin
                rise_q.push_back(cyc);
                if (exp_q.size() > 0) chk("latency", cyc - exp_q[0].acc, W + D);
                else chk("rise_without_word", exp_q.size(), 1);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", exp_q.size(), 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_data", out_data, mon_e.data);
                    chk("mismatch", mismatch, mon_e.mis);
                end
            end
            ov_prev = out_valid;
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [W-1:0] w, input logic [W-1:0] ed, input logic em, input bit keep);
        int   n;
        exp_t e;
        in_data  = w;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        e.data = ed;
        e.mis  = em;
        e.acc  = cyc;
        exp_q.push_back(e);
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk("out_valid_timeout", out_valid, 1);
    endtask

    task automatic handshake();
        wait_valid();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] wv;
        int n;

        // 1: reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_si", si, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mismatch", mismatch, 0);
        rst = 1'b0;
        @(negedge clk);

        // 2: A5 serialised LSB first, then zeros until HOLD
        wv = 8'hA5;
        send(wv, 8'hA5, 1'b0, 1'b0);
        for (int i = 0; i < W; i++) begin
            chk("si_bit", si, wv[i]);
            @(negedge clk);
        end
        for (int i = 0; i < D; i++) begin
            chk("si_drain", si, 0);
            @(negedge clk);
        end
        chk("hold_valid", out_valid, 1);
        handshake();
        chk("post_hs_valid", out_valid, 0);
        chk("post_hs_data_kept", out_data, 8'hA5);
        chk("post_hs_in_ready", in_ready, 1);

        // 3: stall in HOLD for 5 clocks
        send(8'hC3, 8'hC3, 1'b0, 1'b0);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            chk("hold_out_valid", out_valid, 1);
            chk("hold_out_data", out_data, 8'hC3);
            chk("hold_mismatch", mismatch, 0);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_si", si, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("hold_exit_in_ready", in_ready, 1);
        chk("hold_exit_busy", busy, 0);

        // 4: broken line, then healthy line
        force_so = 1'b1;
        send(8'hFF, 8'h00, 1'b1, 1'b0);
        handshake();
        force_so = 1'b0;
        send(8'h0F, 8'h0F, 1'b0, 1'b0);
        handshake();

        // 5: reset while RUN with cnt=6; the word is discarded
        in_data  = 8'h55;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_abort_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_si", si, 0);
        send(8'h3C, 8'h3C, 1'b0, 1'b0);
        handshake();

        // 6: back-to-back words with out_ready held high
        rise_q.delete();
        out_ready = 1'b1;
        send(8'h81, 8'h81, 1'b0, 1'b1);
        send(8'h7E, 8'h7E, 1'b0, 1'b0);
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        out_ready = 1'b0;
        chk("b2b_rises", rise_q.size(), 2);
        if (rise_q.size() >= 2) chk("b2b_spacing", rise_q[1] - rise_q[0], 14);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
